ex_mem_pipe: RTL and testbench

- EX/MEM pipeline register and data-memory access sequencer.
- Sits directly upstream of the memory stage and is the sole source of its XOut, WriteData, MemRead, MemWrite and createdump inputs.
- Holds the in-flight load/store while the multi-cycle data cache reports DC_Stall and freezes the front end.
- Sequences the HALT dump, flags misaligned accesses, and forwards writeback control to MEM/WB.

---
 rtl/ex_mem_pipe_pkg.sv | 25 ++
 rtl/ex_mem_pipe_if.sv | 48 ++++
 rtl/ex_mem_pipe_sat_counter.sv | 31 +++
 rtl/ex_mem_pipe.sv | 90 +++++++++
 tb/tb_ex_mem_pipe.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_pipe_pkg.sv
// Shared types for the EX/MEM pipeline register: FSM encoding and the held bundle.
package ex_mem_pipe_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DUMP   = 2'd1,
    HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] xOut;
    logic [DATA_W-1:0] writeData;
    logic              memRead;
    logic              memWrite;
    logic              regWrite;
    logic [REG_W-1:0]  writeReg;
    logic              memToReg;
    logic              halt;
  } bundle_t;

endpackage

// File: rtl/ex_mem_pipe_if.sv
// EX-side bundle, memory-stage request and MEM/WB control signals of ex_mem_pipe.
interface ex_mem_pipe_if
  import ex_mem_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic              ex_valid;
  logic [DATA_W-1:0] ex_XOut;
  logic [DATA_W-1:0] ex_WriteData;
  logic              ex_MemRead;
  logic              ex_MemWrite;
  logic              ex_RegWrite;
  logic [REG_W-1:0]  ex_WriteReg;
  logic              ex_MemToReg;
  logic              ex_halt;
  logic              flush;
  logic              DC_Stall;

  logic [DATA_W-1:0] XOut;
  logic [DATA_W-1:0] WriteData;
  logic              MemRead;
  logic              MemWrite;
  logic              createdump;
  logic              mem_valid;
  logic              mem_RegWrite;
  logic [REG_W-1:0]  mem_WriteReg;
  logic              mem_MemToReg;
  logic              misalign_err;
  logic              stall_up;
  logic [CNT_W-1:0]  stall_cnt;

  // master: the surrounding pipeline (EX stage + memory stage); slave: the EX/MEM register.
  modport master (
    output ex_valid, ex_XOut, ex_WriteData, ex_MemRead, ex_MemWrite, ex_RegWrite,
           ex_WriteReg, ex_MemToReg, ex_halt, flush, DC_Stall,
    input  XOut, WriteData, MemRead, MemWrite, createdump, mem_valid, mem_RegWrite,
           mem_WriteReg, mem_MemToReg, misalign_err, stall_up, stall_cnt
  );

  modport slave (
    input  ex_valid, ex_XOut, ex_WriteData, ex_MemRead, ex_MemWrite, ex_RegWrite,
           ex_WriteReg, ex_MemToReg, ex_halt, flush, DC_Stall,
    output XOut, WriteData, MemRead, MemWrite, createdump, mem_valid, mem_RegWrite,
           mem_WriteReg, mem_MemToReg, misalign_err, stall_up, stall_cnt
  );

endinterface

// File: rtl/ex_mem_pipe_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module ex_mem_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register: holds a load/store through data-cache stalls,
// sequences the HALT dump and forwards writeback control to MEM/WB.
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  ex_mem_pipe_if.slave bus
);

  state_e  state_q, state_d;
  bundle_t held_q, held_d;
  bundle_t incoming;
  logic    takeEx;
  logic    reqRead, reqWrite;
  logic    memStall;
  logic    stallUp;

  // A killed or empty bundle is captured with every control field cleared;
  // a bundle flagged as both load and store is treated as a store.
  always_comb begin
    takeEx             = bus.ex_valid & ~bus.flush;
    incoming           = '0;
    incoming.valid     = takeEx;
    incoming.xOut      = bus.ex_XOut;
    incoming.writeData = bus.ex_WriteData;
    incoming.memRead   = takeEx & bus.ex_MemRead & ~bus.ex_MemWrite;
    incoming.memWrite  = takeEx & bus.ex_MemWrite;
    incoming.regWrite  = takeEx & bus.ex_RegWrite;
    incoming.writeReg  = takeEx ? bus.ex_WriteReg : '0;
    incoming.memToReg  = takeEx & bus.ex_MemToReg;
    incoming.halt      = takeEx & bus.ex_halt;
  end

  assign reqRead  = held_q.valid & held_q.memRead  & ~held_q.xOut[0] & (state_q == RUN);
  assign reqWrite = held_q.valid & held_q.memWrite & ~held_q.xOut[0] & (state_q == RUN);
  assign memStall = (reqRead | reqWrite) & bus.DC_Stall;
  assign stallUp  = (state_q != RUN) | memStall;

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    case (state_q)
      RUN: begin
        if (!stallUp) begin
          if (held_q.valid && held_q.halt) begin
            state_d = DUMP;
          end else begin
            held_d = incoming;
          end
        end
      end
      DUMP:    state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  ex_mem_sat_counter #(.W(CNT_W)) u_stallCnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (memStall),
    .count_o (bus.stall_cnt)
  );

  assign bus.XOut         = held_q.xOut;
  assign bus.WriteData    = held_q.writeData;
  assign bus.MemRead      = reqRead;
  assign bus.MemWrite     = reqWrite;
  assign bus.createdump   = (state_q == DUMP);
  assign bus.mem_valid    = held_q.valid;
  assign bus.mem_RegWrite = held_q.regWrite;
  assign bus.mem_WriteReg = held_q.writeReg;
  assign bus.mem_MemToReg = held_q.memToReg;
  assign bus.misalign_err = held_q.valid & (held_q.memRead | held_q.memWrite) & held_q.xOut[0];
  assign bus.stall_up     = stallUp;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Vector/scoreboard bench for ex_mem_pipe; a second instance with a 2-bit counter covers saturation.
module tb_ex_mem_pipe;
  import ex_mem_pipe_pkg::*;

  typedef struct packed {
    logic        rstN;
    logic        valid;
    logic [15:0] xout;
    logic [15:0] wdata;
    logic        rd;
    logic        wr;
    logic        rw;
    logic [2:0]  wreg;
    logic        m2r;
    logic        halt;
    logic        flush;
    logic        dcs;
  } in_t;

  typedef struct packed {
    logic        mv;
    logic        rd;
    logic        wr;
    logic        mis;
    logic        rw;
    logic [2:0]  wreg;
    logic        m2r;
    logic        su;
    logic        cd;
    logic [15:0] xout;
    logic [15:0] wdata;
    logic [15:0] cnt;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   vecIdx = 0;
  exp_t sb[$];
  vec_t vecs[$];

  ex_mem_pipe_if #(.CNT_W(16)) busA ();
  ex_mem_pipe_if #(.CNT_W(2))  busB ();

  ex_mem_pipe #(.CNT_W(16)) dutA (.clk(clk), .rst(rst), .bus(busA));
  ex_mem_pipe #(.CNT_W(2))  dutB (.clk(clk), .rst(rst), .bus(busB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t inB(logic v, logic [15:0] x, logic [15:0] wd, logic rd, logic wr,
                              logic rw, logic [2:0] wreg, logic m2r, logic halt, logic flush,
                              logic dcs);
    in_t r;
    r = '{1'b1, v, x, wd, rd, wr, rw, wreg, m2r, halt, flush, dcs};
    return r;
  endfunction

  function automatic exp_t exB(logic mv, logic rd, logic wr, logic mis, logic rw,
                               logic [2:0] wreg, logic m2r, logic su, logic cd,
                               logic [15:0] x, logic [15:0] wd, logic [15:0] cnt);
    exp_t r;
    r = '{mv, rd, wr, mis, rw, wreg, m2r, su, cd, x, wd, cnt};
    return r;
  endfunction

  function automatic exp_t zeroOut(logic [15:0] cnt);
    return exB(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 16'h0, 16'h0, cnt);
  endfunction

  function automatic in_t rstIn();
    in_t r;
    r = '0;
    return r;
  endfunction

  function automatic in_t idleIn(logic dcs);
    return inB(0, 16'h0, 16'h0, 0, 0, 0, 3'd0, 0, 0, 0, dcs);
  endfunction

  function automatic vec_t mk(in_t i, exp_t e);
    vec_t r;
    r.i = i;
    r.e = e;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst                = v.i.rstN;
    busA.ex_valid      = v.i.valid;  busB.ex_valid      = v.i.valid;
    busA.ex_XOut       = v.i.xout;   busB.ex_XOut       = v.i.xout;
    busA.ex_WriteData  = v.i.wdata;  busB.ex_WriteData  = v.i.wdata;
    busA.ex_MemRead    = v.i.rd;     busB.ex_MemRead    = v.i.rd;
    busA.ex_MemWrite   = v.i.wr;     busB.ex_MemWrite   = v.i.wr;
    busA.ex_RegWrite   = v.i.rw;     busB.ex_RegWrite   = v.i.rw;
    busA.ex_WriteReg   = v.i.wreg;   busB.ex_WriteReg   = v.i.wreg;
    busA.ex_MemToReg   = v.i.m2r;    busB.ex_MemToReg   = v.i.m2r;
    busA.ex_halt       = v.i.halt;   busB.ex_halt       = v.i.halt;
    busA.flush         = v.i.flush;  busB.flush         = v.i.flush;
    busA.DC_Stall      = v.i.dcs;    busB.DC_Stall      = v.i.dcs;
    sb.push_back(v.e);
  endtask

  task automatic checkField(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s vec %0d: got %h expected %h", nm, vecIdx, act, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [15:0] smallCnt;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard vec %0d: got empty queue expected an entry", vecIdx);
      return;
    end
    e = sb.pop_front();
    smallCnt = (e.cnt > 16'd3) ? 16'd3 : e.cnt;
    checkField("mem_valid",    {15'd0, busA.mem_valid},    {15'd0, e.mv});
    checkField("MemRead",      {15'd0, busA.MemRead},      {15'd0, e.rd});
    checkField("MemWrite",     {15'd0, busA.MemWrite},     {15'd0, e.wr});
    checkField("misalign_err", {15'd0, busA.misalign_err}, {15'd0, e.mis});
    checkField("mem_RegWrite", {15'd0, busA.mem_RegWrite}, {15'd0, e.rw});
    checkField("mem_WriteReg", {13'd0, busA.mem_WriteReg}, {13'd0, e.wreg});
    checkField("mem_MemToReg", {15'd0, busA.mem_MemToReg}, {15'd0, e.m2r});
    checkField("stall_up",     {15'd0, busA.stall_up},     {15'd0, e.su});
    checkField("createdump",   {15'd0, busA.createdump},   {15'd0, e.cd});
    checkField("XOut",         busA.XOut,                  e.xout);
    checkField("WriteData",    busA.WriteData,             e.wdata);
    checkField("stall_cnt",    busA.stall_cnt,             e.cnt);
    checkField("stall_cnt_w2", {14'd0, busB.stall_cnt},    smallCnt);
    checkField("stall_up_w2",  {15'd0, busB.stall_up},     {15'd0, e.su});
  endtask

  task automatic runVecs();
    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k]);
      @(posedge clk);
      #1;
      checkOutput();
      vecIdx++;
    end
    vecs.delete();
  endtask

  initial begin
    rst = 1'b0;
    busA.ex_valid = 0; busA.ex_XOut = '0; busA.ex_WriteData = '0; busA.ex_MemRead = 0;
    busA.ex_MemWrite = 0; busA.ex_RegWrite = 0; busA.ex_WriteReg = '0; busA.ex_MemToReg = 0;
    busA.ex_halt = 0; busA.flush = 0; busA.DC_Stall = 0;
    busB.ex_valid = 0; busB.ex_XOut = '0; busB.ex_WriteData = '0; busB.ex_MemRead = 0;
    busB.ex_MemWrite = 0; busB.ex_RegWrite = 0; busB.ex_WriteReg = '0; busB.ex_MemToReg = 0;
    busB.ex_halt = 0; busB.flush = 0; busB.DC_Stall = 0;

    // Single-cycle table: reset, idle, ALU, loads/stores, misalignment, flush, junk and dropped halt.
    vecs.push_back(mk(rstIn(), zeroOut(0)));
    vecs.push_back(mk(rstIn(), zeroOut(0)));
    vecs.push_back(mk(idleIn(0), zeroOut(0)));
    vecs.push_back(mk(inB(1, 16'h1234, 16'h0000, 0, 0, 1, 3'd5, 0, 0, 0, 0),
                      exB(1, 0, 0, 0, 1, 3'd5, 0, 0, 0, 16'h1234, 16'h0000, 0)));
    vecs.push_back(mk(inB(1, 16'h0040, 16'h0000, 1, 0, 1, 3'd3, 1, 0, 0, 0),
                      exB(1, 1, 0, 0, 1, 3'd3, 1, 0, 0, 16'h0040, 16'h0000, 0)));
    vecs.push_back(mk(inB(1, 16'h0082, 16'hBEEF, 0, 1, 0, 3'd0, 0, 0, 0, 0),
                      exB(1, 0, 1, 0, 0, 3'd0, 0, 0, 0, 16'h0082, 16'hBEEF, 0)));
    vecs.push_back(mk(inB(1, 16'h0041, 16'h1111, 0, 1, 0, 3'd0, 0, 0, 0, 0),
                      exB(1, 0, 0, 1, 0, 3'd0, 0, 0, 0, 16'h0041, 16'h1111, 0)));
    vecs.push_back(mk(inB(1, 16'h0043, 16'h0000, 1, 0, 1, 3'd2, 1, 0, 0, 0),
                      exB(1, 0, 0, 1, 1, 3'd2, 1, 0, 0, 16'h0043, 16'h0000, 0)));
    vecs.push_back(mk(inB(1, 16'h0010, 16'hCAFE, 1, 1, 0, 3'd0, 0, 0, 0, 0),
                      exB(1, 0, 1, 0, 0, 3'd0, 0, 0, 0, 16'h0010, 16'hCAFE, 0)));
    vecs.push_back(mk(inB(1, 16'h0000, 16'h0000, 0, 1, 1, 3'd4, 0, 0, 1, 0), zeroOut(0)));
    vecs.push_back(mk(inB(0, 16'h0000, 16'h0000, 1, 1, 1, 3'd7, 1, 1, 0, 0), zeroOut(0)));
    vecs.push_back(mk(idleIn(0), zeroOut(0)));
    vecs.push_back(mk(inB(1, 16'h0000, 16'h0000, 0, 0, 0, 3'd0, 0, 1, 1, 0), zeroOut(0)));
    vecs.push_back(mk(idleIn(0), zeroOut(0)));
    runVecs();

    // Load held through a 3-cycle stall; next bundle captured as DC_Stall drops.
    vecs.push_back(mk(rstIn(), zeroOut(0)));
    vecs.push_back(mk(inB(1, 16'h0040, 16'h0000, 1, 0, 1, 3'd1, 1, 0, 0, 0),
                      exB(1, 1, 0, 0, 1, 3'd1, 1, 0, 0, 16'h0040, 16'h0000, 0)));
    for (int k = 1; k <= 3; k++) begin
      vecs.push_back(mk(inB(1, 16'h0777, 16'h0000, 0, 0, 1, 3'd6, 0, 0, 0, 1),
                        exB(1, 1, 0, 0, 1, 3'd1, 1, 1, 0, 16'h0040, 16'h0000, 16'(k))));
    end
    vecs.push_back(mk(inB(1, 16'h0777, 16'h0000, 0, 0, 1, 3'd6, 0, 0, 0, 0),
                      exB(1, 0, 0, 0, 1, 3'd6, 0, 0, 0, 16'h0777, 16'h0000, 3)));
    // Flush is ignored while a store stalls, honoured once the stall clears.
    vecs.push_back(mk(inB(1, 16'h0100, 16'h5555, 0, 1, 0, 3'd0, 0, 0, 0, 0),
                      exB(1, 0, 1, 0, 0, 3'd0, 0, 0, 0, 16'h0100, 16'h5555, 3)));
    for (int k = 4; k <= 5; k++) begin
      vecs.push_back(mk(inB(1, 16'h0200, 16'h0000, 1, 0, 1, 3'd2, 1, 0, 1, 1),
                        exB(1, 0, 1, 0, 0, 3'd0, 0, 1, 0, 16'h0100, 16'h5555, 16'(k))));
    end
    vecs.push_back(mk(inB(1, 16'h0000, 16'h0000, 1, 0, 1, 3'd2, 1, 0, 1, 0), zeroOut(5)));
    runVecs();

    // Six stall cycles: the 16-bit counter reaches 6, the 2-bit one sticks at 3.
    vecs.push_back(mk(rstIn(), zeroOut(0)));
    vecs.push_back(mk(inB(1, 16'h0040, 16'h0000, 1, 0, 0, 3'd0, 0, 0, 0, 0),
                      exB(1, 1, 0, 0, 0, 3'd0, 0, 0, 0, 16'h0040, 16'h0000, 0)));
    for (int k = 1; k <= 6; k++) begin
      vecs.push_back(mk(idleIn(1), exB(1, 1, 0, 0, 0, 3'd0, 0, 1, 0, 16'h0040, 16'h0000, 16'(k))));
    end
    vecs.push_back(mk(idleIn(0), zeroOut(6)));
    runVecs();

    // Halt: one dump pulse, then a permanent freeze that ignores new bundles.
    vecs.push_back(mk(rstIn(), zeroOut(0)));
    vecs.push_back(mk(inB(1, 16'h0000, 16'h0000, 0, 0, 0, 3'd0, 0, 1, 0, 0),
                      exB(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 16'h0000, 16'h0000, 0)));
    vecs.push_back(mk(inB(1, 16'h0999, 16'h0000, 0, 0, 1, 3'd4, 0, 0, 0, 0),
                      exB(1, 0, 0, 0, 0, 3'd0, 0, 1, 1, 16'h0000, 16'h0000, 0)));
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(inB(1, 16'h0999, 16'h0000, 0, 0, 1, 3'd4, 0, 0, 0, 0),
                        exB(1, 0, 0, 0, 0, 3'd0, 0, 1, 0, 16'h0000, 16'h0000, 0)));
    end
    runVecs();

    // Reset during the dump pulse returns to RUN and capture resumes.
    vecs.push_back(mk(rstIn(), zeroOut(0)));
    vecs.push_back(mk(inB(1, 16'h0000, 16'h0000, 0, 0, 0, 3'd0, 0, 1, 0, 0),
                      exB(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 16'h0000, 16'h0000, 0)));
    vecs.push_back(mk(idleIn(0), exB(1, 0, 0, 0, 0, 3'd0, 0, 1, 1, 16'h0000, 16'h0000, 0)));
    vecs.push_back(mk(rstIn(), zeroOut(0)));
    vecs.push_back(mk(idleIn(0), zeroOut(0)));
    vecs.push_back(mk(inB(1, 16'h0999, 16'h0000, 0, 0, 1, 3'd4, 0, 0, 0, 0),
                      exB(1, 0, 0, 0, 1, 3'd4, 0, 0, 0, 16'h0999, 16'h0000, 0)));
    runVecs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
